// File: rtl/vx_mem_tag_remap.sv
// rtl/vx_mem_tag_remap.sv - swaps wide arbiter tags for compact slot indices and restores them on response
module vx_mem_tag_remap #(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_IN_WIDTH = 10,
    parameter int NUM_SLOTS    = 16,
    localparam int DATA_SIZE     = DATA_WIDTH / 8,
    localparam int TAG_OUT_WIDTH = $clog2(NUM_SLOTS)
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      req_valid_in,
    input  logic [TAG_IN_WIDTH-1:0]   req_tag_in,
    input  logic [ADDR_WIDTH-1:0]     req_addr_in,
    input  logic                      req_rw_in,
    input  logic [DATA_SIZE-1:0]      req_byteen_in,
    input  logic [DATA_WIDTH-1:0]     req_data_in,
    output logic                      req_ready_in,

    output logic                      req_valid_out,
    output logic [TAG_OUT_WIDTH-1:0]  req_tag_out,
    output logic [ADDR_WIDTH-1:0]     req_addr_out,
    output logic                      req_rw_out,
    output logic [DATA_SIZE-1:0]      req_byteen_out,
    output logic [DATA_WIDTH-1:0]     req_data_out,
    input  logic                      req_ready_out,

    input  logic                      rsp_valid_in,
    input  logic [TAG_OUT_WIDTH-1:0]  rsp_tag_in,
    input  logic [DATA_WIDTH-1:0]     rsp_data_in,
    output logic                      rsp_ready_in,

    output logic                      rsp_valid_out,
    output logic [TAG_IN_WIDTH-1:0]   rsp_tag_out,
    output logic [DATA_WIDTH-1:0]     rsp_data_out,
    input  logic                      rsp_ready_out,

    output logic [TAG_OUT_WIDTH:0]    pending_count,
    output logic                      full,
    output logic                      err_unexp
);

    localparam logic [TAG_OUT_WIDTH:0] FULL_COUNT = (TAG_OUT_WIDTH + 1)'(NUM_SLOTS);

    logic [NUM_SLOTS-1:0]     busy;
    logic [TAG_IN_WIDTH-1:0]  tag_table [NUM_SLOTS];
    logic [TAG_OUT_WIDTH:0]   count;
    logic                     rsp_valid_q;
    logic [TAG_IN_WIDTH-1:0]  rsp_tag_q;
    logic [DATA_WIDTH-1:0]    rsp_data_q;
    logic                     err_q;

    logic [TAG_OUT_WIDTH-1:0] alloc_idx;
    logic                     read_ok;
    logic                     alloc_fire;
    logic                     rsp_fire;
    logic                     rsp_hit;
    logic [NUM_SLOTS-1:0]     alloc_mask;
    logic [NUM_SLOTS-1:0]     free_mask;

    // Scan downward so the last assignment wins: the lowest clear bit.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_idx = TAG_OUT_WIDTH'(i);
            end
        end
    end

    assign full          = (count == FULL_COUNT);
    assign read_ok       = req_rw_in || !full;

    assign req_valid_out  = req_valid_in && read_ok;
    assign req_ready_in   = req_ready_out && read_ok;
    assign req_tag_out    = req_rw_in ? '0 : alloc_idx;
    assign req_addr_out   = req_addr_in;
    assign req_rw_out     = req_rw_in;
    assign req_byteen_out = req_byteen_in;
    assign req_data_out   = req_data_in;

    assign alloc_fire = req_valid_in && req_ready_in && !req_rw_in;

    assign rsp_ready_in = !rsp_valid_q || rsp_ready_out;
    assign rsp_fire     = rsp_valid_in && rsp_ready_in;
    assign rsp_hit      = rsp_fire && busy[rsp_tag_in];

    assign alloc_mask = alloc_fire ? (NUM_SLOTS'(1) << alloc_idx) : '0;
    assign free_mask  = rsp_hit ? (NUM_SLOTS'(1) << rsp_tag_in) : '0;

    // Slot allocation bookkeeping; a busy slot is never reallocated, so masks never overlap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy  <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            busy <= (busy | alloc_mask) & ~free_mask;
            case ({alloc_fire, rsp_hit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (rsp_fire && !busy[rsp_tag_in]) begin
                err_q <= 1'b1;
            end
        end
    end

    // Table contents are only meaningful for busy slots, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            tag_table[alloc_idx] <= req_tag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
        end else if (rsp_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_tag_q   <= tag_table[rsp_tag_in];
            rsp_data_q  <= rsp_data_in;
        end else if (rsp_ready_out) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_out = rsp_valid_q;
    assign rsp_tag_out   = rsp_tag_q;
    assign rsp_data_out  = rsp_data_q;
    assign pending_count = count;
    assign err_unexp     = err_q;

endmodule

// File: tb/tb_vx_mem_tag_remap.sv
// tb/tb_vx_mem_tag_remap.sv - directed and random checks of vx_mem_tag_remap against a slot-table model
module tb_vx_mem_tag_remap;

    localparam int DW = 64;
    localparam int AW = 26;
    localparam int TW = 10;
    localparam int NS = 16;
    localparam int BW = DW / 8;
    localparam int OW = $clog2(NS);

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid_in;
    logic [TW-1:0] req_tag_in;
    logic [AW-1:0] req_addr_in;
    logic          req_rw_in;
    logic [BW-1:0] req_byteen_in;
    logic [DW-1:0] req_data_in;
    logic          req_ready_in;
    logic          req_valid_out;
    logic [OW-1:0] req_tag_out;
    logic [AW-1:0] req_addr_out;
    logic          req_rw_out;
    logic [BW-1:0] req_byteen_out;
    logic [DW-1:0] req_data_out;
    logic          req_ready_out;
    logic          rsp_valid_in;
    logic [OW-1:0] rsp_tag_in;
    logic [DW-1:0] rsp_data_in;
    logic          rsp_ready_in;
    logic          rsp_valid_out;
    logic [TW-1:0] rsp_tag_out;
    logic [DW-1:0] rsp_data_out;
    logic          rsp_ready_out;
    logic [OW:0]   pending_count;
    logic          full;
    logic          err_unexp;

    vx_mem_tag_remap #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .NUM_SLOTS(NS)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_tag_in(req_tag_in), .req_addr_in(req_addr_in),
        .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in), .req_data_in(req_data_in),
        .req_ready_in(req_ready_in),
        .req_valid_out(req_valid_out), .req_tag_out(req_tag_out), .req_addr_out(req_addr_out),
        .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out), .req_data_out(req_data_out),
        .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_tag_in(rsp_tag_in), .rsp_data_in(rsp_data_in),
        .rsp_ready_in(rsp_ready_in),
        .rsp_valid_out(rsp_valid_out), .rsp_tag_out(rsp_tag_out), .rsp_data_out(rsp_data_out),
        .rsp_ready_out(rsp_ready_out),
        .pending_count(pending_count), .full(full), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: which slots hold an outstanding read and the tag each one owes back.
    bit            m_busy [NS];
    bit [TW-1:0]   m_tab  [NS];
    bit            m_err;
    bit            m_rv;
    bit [TW-1:0]   m_rtag;
    bit [DW-1:0]   m_rdata;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int m_outstanding();
        int n = 0;
        for (int i = 0; i < NS; i++) n += m_busy[i];
        return n;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < NS; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    // One clock: check the combinational request/response handshake, advance the model, check registers.
    task automatic cycle();
        bit is_full, accept_req, accept_rsp, took, hit;
        int slot;
        #1;
        is_full    = (m_outstanding() == NS);
        accept_req = req_ready_out && (req_rw_in || !is_full);
        accept_rsp = !m_rv || rsp_ready_out;
        chk("req_valid_out", req_valid_out, req_valid_in && (req_rw_in || !is_full));
        chk("req_ready_in", req_ready_in, accept_req);
        chk("rsp_ready_in", rsp_ready_in, accept_rsp);
        chk("req_addr_out", req_addr_out, req_addr_in);
        chk("req_data_out", req_data_out, req_data_in);
        chk("req_byteen_out", req_byteen_out, req_byteen_in);
        chk("req_rw_out", req_rw_out, req_rw_in);
        if (req_rw_in) chk("req_tag_out_wr", req_tag_out, 0);
        else if (!is_full) chk("req_tag_out_rd", req_tag_out, m_first_free());

        if (!reset) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_err = 0; m_rv = 0; m_rtag = 0; m_rdata = 0;
        end else begin
            took = req_valid_in && accept_req && !req_rw_in;
            slot = m_first_free();
            hit  = 0;
            if (rsp_valid_in && accept_rsp) begin
                if (m_busy[rsp_tag_in]) begin
                    hit = 1;
                    m_rv = 1; m_rtag = m_tab[rsp_tag_in]; m_rdata = rsp_data_in;
                    m_busy[rsp_tag_in] = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (!hit && rsp_ready_out) m_rv = 0;
            if (took) begin
                m_busy[slot] = 1;
                m_tab[slot]  = req_tag_in;
            end
        end

        @(posedge clk);
        #1;
        chk("pending_count", pending_count, m_outstanding());
        chk("full", full, m_outstanding() == NS);
        chk("err_unexp", err_unexp, m_err);
        chk("rsp_valid_out", rsp_valid_out, m_rv);
        if (m_rv || !reset) begin
            chk("rsp_tag_out", rsp_tag_out, m_rtag);
            chk("rsp_data_out", rsp_data_out, m_rdata);
        end
    endtask

    task automatic idle();
        req_valid_in = 0; req_rw_in = 0; req_tag_in = '0;
        rsp_valid_in = 0; rsp_tag_in = '0;
    endtask

    task automatic rd(input logic [TW-1:0] t);
        req_valid_in = 1; req_rw_in = 0; req_tag_in = t;
        req_addr_in = AW'($urandom); req_data_in = {$urandom, $urandom}; req_byteen_in = BW'($urandom);
    endtask

    task automatic rsp(input int s);
        rsp_valid_in = 1; rsp_tag_in = OW'(s); rsp_data_in = {$urandom, $urandom};
    endtask

    initial begin
        int q[$];
        reset = 0; req_ready_out = 1; rsp_ready_out = 1;
        req_addr_in = '0; req_data_in = '0; req_byteen_in = '0; rsp_data_in = '0;
        idle();
        cycle(); cycle();
        chk("reset_pending", pending_count, 0);
        chk("reset_rsp_valid", rsp_valid_out, 0);
        reset = 1;

        // Single read, then its response.
        rd(10'h2A5);
        #1 chk("t1_req_tag", req_tag_out, 0);
        cycle(); idle();
        chk("t1_pending", pending_count, 1);
        rsp(0); cycle(); idle();
        chk("t1_rsp_tag", rsp_tag_out, 10'h2A5);
        chk("t1_pending_after", pending_count, 0);
        cycle();

        // Fill all slots, then a stalled read and a passing write.
        for (int i = 0; i < NS; i++) begin rd(TW'(i + 16)); cycle(); end
        chk("t2_full", full, 1);
        rd(10'h3FF); cycle();
        req_rw_in = 1; cycle();
        chk("t2_wr_ready", req_ready_in, 1);

        // Free slot 5 while full; the read waits one extra cycle, then takes slot 5.
        rd(10'h155); rsp(5); cycle();
        rsp_valid_in = 0; cycle();
        chk("t3_pending", pending_count, NS);
        idle(); rsp(5); cycle(); idle(); cycle();

        // Out-of-order returns with a stalled output stage.
        rsp(3); rsp_ready_out = 1; cycle();
        rsp(0); rsp_ready_out = 0; cycle(); cycle();
        rsp_ready_out = 1; cycle();
        rsp(2); cycle(); idle(); cycle();

        // Allocate and free together at pending_count 4.
        reset = 0; cycle(); reset = 1;
        for (int i = 0; i < 4; i++) begin rd(TW'(i + 100)); cycle(); end
        rd(10'h0AB); rsp(1); cycle(); idle();
        chk("t5_pending", pending_count, 4);
        rd(10'h0CD); #1 chk("t5_next_tag", req_tag_out, 1);
        cycle(); idle(); cycle();

        // Unexpected response, then reset clears the sticky error.
        rsp(7); cycle(); idle(); cycle();
        chk("t6_err", err_unexp, 1);
        reset = 0; cycle(); reset = 1;
        chk("t6_err_cleared", err_unexp, 0);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            req_valid_in  = ($urandom_range(0, 2) != 0);
            req_rw_in     = ($urandom_range(0, 3) == 0);
            req_tag_in    = TW'($urandom);
            req_addr_in   = AW'($urandom);
            req_byteen_in = BW'($urandom);
            req_data_in   = {$urandom, $urandom};
            req_ready_out = ($urandom_range(0, 3) != 0);
            rsp_ready_out = ($urandom_range(0, 3) != 0);
            rsp_valid_in  = ($urandom_range(0, 1) != 0);
            rsp_data_in   = {$urandom, $urandom};
            q.delete();
            for (int i = 0; i < NS; i++) if (m_busy[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 9) != 0) rsp_tag_in = OW'(q[$urandom_range(0, q.size() - 1)]);
            else rsp_tag_in = OW'($urandom);
            reset = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
